// File: rtl/core_decode_stage.sv
// Registered RV32I decode stage: combinational decode of the fetched word into a one-entry
// pipeline register with valid/ready handshake, flush and load-use bubble insertion.
module core_decode_stage #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned ALU_OP_WIDTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [31:0]               instr_i,
  input  logic [ADDR_WIDTH-1:0]     pc_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_o,
  output logic                      is_imm_rs1_o,
  output logic [XLEN-1:0]           imm_rs1_o,
  output logic                      is_imm_rs2_o,
  output logic [XLEN-1:0]           imm_rs2_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      reg_w_o,
  output logic                      mem_r_o,
  output logic                      mem_w_o,
  output logic [2:0]                mem_funct3_o,
  output logic                      branch_o,
  output logic                      jump_o,
  output logic                      jalr_o,
  output logic [ADDR_WIDTH-1:0]     target_o,
  output logic                      illegal_o
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [ALU_OP_WIDTH-1:0] AluAdd  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] AluSub  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] AluSll  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] AluSlt  = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] AluSltu = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] AluXor  = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] AluSrl  = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] AluSra  = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] AluOr   = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] AluAnd  = ALU_OP_WIDTH'(9);

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0]   alu_op;
    logic                      is_imm_rs1;
    logic [XLEN-1:0]           imm_rs1;
    logic                      is_imm_rs2;
    logic [XLEN-1:0]           imm_rs2;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_w;
    logic                      mem_r;
    logic                      mem_w;
    logic [2:0]                mem_funct3;
    logic                      branch;
    logic                      jump;
    logic                      jalr;
    logic [ADDR_WIDTH-1:0]     target;
    logic                      illegal;
  } dec_t;

  // alt selects SUB/SRA over ADD/SRL (funct7 bit 5)
  function automatic logic [ALU_OP_WIDTH-1:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [ALU_OP_WIDTH-1:0] op;
    unique case (f3)
      3'd0:    op = alt ? AluSub : AluAdd;
      3'd1:    op = AluSll;
      3'd2:    op = AluSlt;
      3'd3:    op = AluSltu;
      3'd4:    op = AluXor;
      3'd5:    op = alt ? AluSra : AluSrl;
      3'd6:    op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  logic [REG_ADDR_WIDTH-1:0] rd_f, rs1_f, rs2_f;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign funct7  = instr_i[31:25];
  assign rd_f    = REG_ADDR_WIDTH'(instr_i[11:7]);
  assign rs1_f   = REG_ADDR_WIDTH'(instr_i[19:15]);
  assign rs2_f   = REG_ADDR_WIDTH'(instr_i[24:20]);
  assign imm_i32 = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8],
                    1'b0};
  assign imm_u32 = {instr_i[31:12], 12'b0};
  assign imm_j32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                    1'b0};

  dec_t dec;
  dec_t dec_q;
  logic valid_q;
  logic legal;
  logic hazard;
  logic capture;

  // Combinational decode of the incoming word; unused register indices stay 0.
  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OpLui: begin
        legal          = 1'b1;
        dec.rd_addr    = rd_f;
        dec.reg_w      = 1'b1;
        dec.is_imm_rs2 = 1'b1;
        dec.imm_rs2    = XLEN'($signed(imm_u32));
      end
      OpAuipc: begin
        legal          = 1'b1;
        dec.rd_addr    = rd_f;
        dec.reg_w      = 1'b1;
        dec.is_imm_rs1 = 1'b1;
        dec.imm_rs1    = XLEN'(pc_i);
        dec.is_imm_rs2 = 1'b1;
        dec.imm_rs2    = XLEN'($signed(imm_u32));
      end
      OpJal, OpJalr: begin
        legal          = (opcode == OpJal) || (funct3 == 3'd0);
        dec.rd_addr    = rd_f;
        dec.reg_w      = 1'b1;
        dec.jump       = 1'b1;
        dec.is_imm_rs1 = 1'b1;
        dec.imm_rs1    = XLEN'(pc_i);
        dec.is_imm_rs2 = 1'b1;
        dec.imm_rs2    = XLEN'(4);
        if (opcode == OpJal) begin
          dec.target = pc_i + ADDR_WIDTH'($signed(imm_j32));
        end else begin
          // execute adds rs1 to this offset and clears bit 0
          dec.jalr     = 1'b1;
          dec.rs1_addr = rs1_f;
          dec.target   = ADDR_WIDTH'($signed(imm_i32));
        end
      end
      OpBranch: begin
        legal          = (funct3 != 3'd2) && (funct3 != 3'd3);
        dec.rs1_addr   = rs1_f;
        dec.rs2_addr   = rs2_f;
        dec.alu_op     = AluSub;
        dec.branch     = 1'b1;
        dec.mem_funct3 = funct3;
        dec.target     = pc_i + ADDR_WIDTH'($signed(imm_b32));
      end
      OpLoad: begin
        legal          = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        dec.rs1_addr   = rs1_f;
        dec.rd_addr    = rd_f;
        dec.reg_w      = 1'b1;
        dec.mem_r      = 1'b1;
        dec.mem_funct3 = funct3;
        dec.is_imm_rs2 = 1'b1;
        dec.imm_rs2    = XLEN'($signed(imm_i32));
      end
      OpStore: begin
        legal          = (funct3 <= 3'd2);
        dec.rs1_addr   = rs1_f;
        dec.rs2_addr   = rs2_f;
        dec.mem_w      = 1'b1;
        dec.mem_funct3 = funct3;
        dec.is_imm_rs2 = 1'b1;
        dec.imm_rs2    = XLEN'($signed(imm_s32));
      end
      OpImm: begin
        if (funct3 == 3'd1) begin
          legal = (funct7 == 7'h00);
        end else if (funct3 == 3'd5) begin
          legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        end else begin
          legal = 1'b1;
        end
        dec.rs1_addr   = rs1_f;
        dec.rd_addr    = rd_f;
        dec.reg_w      = 1'b1;
        dec.is_imm_rs2 = 1'b1;
        dec.imm_rs2    = XLEN'($signed(imm_i32));
        dec.alu_op     = alu_of(funct3, (funct3 == 3'd5) && funct7[5]);
      end
      OpReg: begin
        legal        = (funct7 == 7'h00) ||
                       ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
        dec.rs1_addr = rs1_f;
        dec.rs2_addr = rs2_f;
        dec.rd_addr  = rd_f;
        dec.reg_w    = 1'b1;
        dec.alu_op   = alu_of(funct3, funct7[5]);
      end
      OpFence: begin
        legal = (funct3 == 3'd0);
      end
      OpSystem: begin
        legal = (instr_i == 32'h0000_0073) || (instr_i == 32'h0010_0073);
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    if (dec.rd_addr == '0) begin
      dec.reg_w = 1'b0;
    end
  end

  // Load-use: held load writes a register the incoming instruction reads.
  always_comb begin
    hazard  = valid_i && valid_q && dec_q.mem_r && (dec_q.rd_addr != '0) &&
              ((dec.rs1_addr == dec_q.rd_addr) || (dec.rs2_addr == dec_q.rd_addr));
    ready_o = (!valid_q || ready_i) && !hazard;
    capture = valid_i && ready_o && !flush_i;
  end

  // Pipeline register: reset > flush > capture > drain on consume.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      dec_q   <= dec;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o      = valid_q;
  assign alu_op_o     = dec_q.alu_op;
  assign is_imm_rs1_o = dec_q.is_imm_rs1;
  assign imm_rs1_o    = dec_q.imm_rs1;
  assign is_imm_rs2_o = dec_q.is_imm_rs2;
  assign imm_rs2_o    = dec_q.imm_rs2;
  assign rs1_addr_o   = dec_q.rs1_addr;
  assign rs2_addr_o   = dec_q.rs2_addr;
  assign rd_addr_o    = dec_q.rd_addr;
  assign reg_w_o      = dec_q.reg_w;
  assign mem_r_o      = dec_q.mem_r;
  assign mem_w_o      = dec_q.mem_w;
  assign mem_funct3_o = dec_q.mem_funct3;
  assign branch_o     = dec_q.branch;
  assign jump_o       = dec_q.jump;
  assign jalr_o       = dec_q.jalr;
  assign target_o     = dec_q.target;
  assign illegal_o    = dec_q.illegal;

endmodule

// File: tb/tb_core_decode_stage.sv
// Bench for core_decode_stage: directed scenarios plus randomized traffic against a
// mnemonic-level decode model and a one-entry pipeline model.
module tb_core_decode_stage;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                         XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic [31:0] instr_i, pc_i;
  logic        ready_o, valid_o;
  logic [3:0]  alu_op_o;
  logic        is_imm_rs1_o, is_imm_rs2_o;
  logic [31:0] imm_rs1_o, imm_rs2_o, target_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic        reg_w_o, mem_r_o, mem_w_o, branch_o, jump_o, jalr_o, illegal_o;
  logic [2:0]  mem_funct3_o;

  core_decode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .valid_o(valid_o), .ready_i(ready_i),
    .alu_op_o(alu_op_o), .is_imm_rs1_o(is_imm_rs1_o), .imm_rs1_o(imm_rs1_o),
    .is_imm_rs2_o(is_imm_rs2_o), .imm_rs2_o(imm_rs2_o), .rs1_addr_o(rs1_addr_o),
    .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .reg_w_o(reg_w_o), .mem_r_o(mem_r_o),
    .mem_w_o(mem_w_o), .mem_funct3_o(mem_funct3_o), .branch_o(branch_o), .jump_o(jump_o),
    .jalr_o(jalr_o), .target_o(target_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  alu;
    logic        is1;
    logic [31:0] imm1;
    logic        is2;
    logic [31:0] imm2;
    logic [4:0]  rs1, rs2, rd;
    logic        regw, memr, memw;
    logic [2:0]  f3;
    logic        br, jmp, jalr;
    logic [31:0] tgt;
    logic        ill;
  } ent_t;

  int   n_checks = 0;
  int   n_errors = 0;
  logic mv;
  ent_t me;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ctl_of(input ent_t e);
    return {e.alu, e.is1, e.is2, e.rs1, e.rs2, e.rd, e.regw, e.memr, e.memw, e.f3, e.br, e.jmp,
            e.jalr, e.ill};
  endfunction

  function automatic ent_t dut_ent();
    ent_t e;
    e.alu = alu_op_o; e.is1 = is_imm_rs1_o; e.imm1 = imm_rs1_o; e.is2 = is_imm_rs2_o;
    e.imm2 = imm_rs2_o; e.rs1 = rs1_addr_o; e.rs2 = rs2_addr_o; e.rd = rd_addr_o;
    e.regw = reg_w_o; e.memr = mem_r_o; e.memw = mem_w_o; e.f3 = mem_funct3_o;
    e.br = branch_o; e.jmp = jump_o; e.jalr = jalr_o; e.tgt = target_o; e.ill = illegal_o;
    return e;
  endfunction

  // Reference decode written per instruction class, immediates from signed arithmetic.
  function automatic ent_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    ent_t e;
    int   si, ii, is, ib, iu, ij, f3, f7, rd, r1, r2;
    logic ok;
    logic [3:0] by_f3 [8];
    by_f3 = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    si = int'(ins);
    ii = si >>> 20;
    is = ((si >>> 25) <<< 5) | int'(ins[11:7]);
    ib = ((si >>> 31) <<< 12) | (int'(ins[7]) <<< 11) | (int'(ins[30:25]) <<< 5) |
         (int'(ins[11:8]) <<< 1);
    iu = si & 32'hFFFF_F000;
    ij = ((si >>> 31) <<< 20) | (int'(ins[19:12]) <<< 12) | (int'(ins[20]) <<< 11) |
         (int'(ins[30:21]) <<< 1);
    f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    rd = int'(ins[11:7]); r1 = int'(ins[19:15]); r2 = int'(ins[24:20]);
    e  = '0;
    ok = 1'b0;
    case (ins[6:0])
      7'h37: begin ok = 1; e.rd = rd; e.regw = 1; e.is2 = 1; e.imm2 = iu; e.alu = ADD; end
      7'h17: begin ok = 1; e.rd = rd; e.regw = 1; e.is1 = 1; e.imm1 = pc; e.is2 = 1; e.imm2 = iu; end
      7'h6F: begin
        ok = 1; e.rd = rd; e.regw = 1; e.is1 = 1; e.imm1 = pc; e.is2 = 1; e.imm2 = 4;
        e.jmp = 1; e.tgt = pc + ij;
      end
      7'h67: begin
        ok = (f3 == 0); e.rd = rd; e.rs1 = r1; e.regw = 1; e.is1 = 1; e.imm1 = pc; e.is2 = 1;
        e.imm2 = 4; e.jmp = 1; e.jalr = 1; e.tgt = ii;
      end
      7'h63: begin
        ok = (f3 inside {0, 1, 4, 5, 6, 7}); e.rs1 = r1; e.rs2 = r2; e.alu = SUB; e.br = 1;
        e.f3 = f3[2:0]; e.tgt = pc + ib;
      end
      7'h03: begin
        ok = (f3 inside {0, 1, 2, 4, 5}); e.rs1 = r1; e.rd = rd; e.regw = 1; e.memr = 1;
        e.f3 = f3[2:0]; e.is2 = 1; e.imm2 = ii;
      end
      7'h23: begin
        ok = (f3 inside {0, 1, 2}); e.rs1 = r1; e.rs2 = r2; e.memw = 1; e.f3 = f3[2:0];
        e.is2 = 1; e.imm2 = is;
      end
      7'h13: begin
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
        e.rs1 = r1; e.rd = rd; e.regw = 1; e.is2 = 1; e.imm2 = ii;
        e.alu = (f3 == 5 && f7 == 32) ? SRA : by_f3[f3];
      end
      7'h33: begin
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.regw = 1;
        e.alu = (f7 == 32) ? ((f3 == 0) ? SUB : SRA) : by_f3[f3];
      end
      7'h0F: ok = (f3 == 0);
      7'h73: ok = (ins == 32'h0000_0073) || (ins == 32'h0010_0073);
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0;
      e.ill = 1;
    end
    if (e.rd == 0) e.regw = 0;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  ops [11];
    int          k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w  = $urandom;
    rd = 5'($urandom_range(0, 3)); r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    k = $urandom_range(0, 12);
    if (k == 12) return w;
    if (k == 11) begin
      case ($urandom_range(0, 2))
        0:       return 32'h0000_0073;
        1:       return 32'h0010_0073;
        default: return {w[31:7], 7'h73};
      endcase
    end
    if ((ops[k] == 7'h67 || ops[k] == 7'h0F) && $urandom_range(0, 3) != 0) f3 = 3'd0;
    if (ops[k] == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) w[31:25] = f7;
    if (ops[k] == 7'h33) w[31:25] = f7;
    return {w[31:25], r2, r1, f3, rd, ops[k]};
  endfunction

  // One cycle: check held entry, drive inputs, check ready_o, advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic rs);
    ent_t nx, got;
    logic haz, exp_rdy;
    @(negedge clk_i);
    check("valid", valid_o, mv);
    if (mv) begin
      got = dut_ent();
      check("ctl", ctl_of(got), ctl_of(me));
      check("imm1", got.imm1, me.imm1);
      check("imm2", got.imm2, me.imm2);
      check("target", got.tgt, me.tgt);
    end
    valid_i = v; instr_i = ins; pc_i = pc; ready_i = rdy; flush_i = fl; rst_i = rs;
    #1;
    nx      = ref_dec(ins, pc);
    haz     = v && mv && me.memr && (me.rd != 0) && (nx.rs1 == me.rd || nx.rs2 == me.rd);
    exp_rdy = (!mv || rdy) && !haz;
    check("ready", ready_o, exp_rdy);
    if (rs) begin
      mv = 0; me = '0;
    end else if (fl) begin
      mv = 0;
    end else if (v && exp_rdy) begin
      mv = 1; me = nx;
    end else if (rdy) begin
      mv = 0;
    end
  endtask

  task automatic settle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1; flush_i = 0; valid_i = 0; ready_i = 0; instr_i = 0; pc_i = 0;
    mv = 0; me = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_ctl", ctl_of(dut_ent()), 0);
    check("rst_imm", {imm_rs1_o, imm_rs2_o}, 0);
    check("rst_tgt", target_o, 0);

    // addi x1,x0,-5
    step(1, 32'hFFB0_0093, 32'h0, 1, 0, 0); settle();
    check("addi_valid", valid_o, 1);
    check("addi_imm", imm_rs2_o, 32'hFFFF_FFFB);
    check("addi_rd", {rd_addr_o, reg_w_o, alu_op_o, is_imm_rs2_o}, {5'd1, 1'b1, ADD, 1'b1});

    // lw x2,0(x1) then add x3,x2,x2
    step(1, 32'h0000_A103, 32'h4, 1, 0, 0);
    step(1, 32'h0021_01B3, 32'h8, 1, 0, 0);
    check("haz_ready", ready_o, 0);
    settle();
    check("bubble", valid_o, 0);
    step(1, 32'h0021_01B3, 32'h8, 1, 0, 0); settle();
    check("add_issue", {valid_o, rd_addr_o}, {1'b1, 5'd3});

    // Stall for three cycles with addi x5,x0,7 waiting
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h0070_0293, 32'hC, 0, 0, 0); settle();
      check("stall_ready", ready_o, 0);
      check("stall_hold", {valid_o, rd_addr_o, rs2_addr_o}, {1'b1, 5'd3, 5'd2});
    end
    step(1, 32'h0070_0293, 32'hC, 1, 0, 0); settle();
    check("stall_release", {valid_o, rd_addr_o, imm_rs2_o}, {1'b1, 5'd5, 32'd7});

    // beq x1,x2,-8 at 0x100
    step(1, 32'hFE20_8CE3, 32'h100, 1, 0, 0); settle();
    check("beq", {branch_o, mem_funct3_o, reg_w_o}, {1'b1, 3'd0, 1'b0});
    check("beq_target", target_o, 32'h0F8);

    // Flush with valid_i=1 and valid_o=1
    step(1, 32'h0070_0293, 32'h104, 1, 1, 0); settle();
    check("flush", valid_o, 0);

    step(1, 32'hFFFF_FFFF, 32'h200, 1, 0, 0); settle();
    check("ill_ones", {valid_o, illegal_o, reg_w_o, mem_r_o, mem_w_o, branch_o, jump_o},
          7'b1100000);
    step(1, 32'h0231_00B3, 32'h204, 1, 0, 0); settle();
    check("ill_mul", {valid_o, illegal_o, reg_w_o, mem_r_o, mem_w_o, branch_o, jump_o},
          7'b1100000);

    // Reset in the middle of a stall
    step(1, 32'h0070_0293, 32'h208, 1, 0, 0);
    step(1, 32'h0010_0113, 32'h20C, 0, 0, 0); settle();
    check("mid_stall_ready", ready_o, 0);
    step(0, 32'h0, 32'h0, 0, 0, 1); settle();
    check("rst_stall_valid", {valid_o, ready_o}, 2'b01);
    check("rst_stall_ctl", ctl_of(dut_ent()), 0);
    check("rst_stall_data", {imm_rs1_o, imm_rs2_o}, 0);
    step(0, 32'h0, 32'h0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, gen_instr(), {$urandom, 2'b00} & 32'hFFFF_FFFC,
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end
    step(0, 32'h0, 32'h0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
